// File: rtl/descent_step_sequencer.sv
// Serial step-index sequencer for one left-descent of the SC decoder tree.
// It walks from the entry layer's base index down to the leaf step N-2, one step per handshake.
module descent_step_sequencer #(
   parameter int unsigned COUNTER_WIDTH   = 10,
   parameter int unsigned LAYER_OUT_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [LAYER_OUT_WIDTH-1:0] entry_layer,
   input  logic                       entry_is_g,
   input  logic                       abort,
   input  logic                       step_ready,
   output logic                       step_valid,
   output logic [COUNTER_WIDTH-1:0]   counter_value,
   output logic                       op_is_g,
   output logic                       layer_first,
   output logic                       busy,
   output logic                       descent_done,
   output logic                       bad_start
);

   localparam int unsigned CW = COUNTER_WIDTH;
   localparam int unsigned LW = LAYER_OUT_WIDTH;
   localparam logic [CW-1:0] LAST      = CW'((2 ** CW) - 2);
   localparam logic [LW-1:0] MAX_LAYER = LW'(CW - 1);
   localparam logic [CW:0]   N_FULL    = (CW + 1)'(1) << CW;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] counter_q, counter_d;
   logic [CW-1:0] g_limit_q, g_limit_d;
   logic          g_flag_q, g_flag_d;
   logic          bad_start_q, bad_start_d;

   logic [LW:0]   layer_p1_c;
   logic [CW:0]   base_wide_c;
   logic [CW:0]   limit_wide_c;
   logic          legal_c;
   logic [CW-1:0] inv_c;
   logic [CW-1:0] inv_p1_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         counter_q   <= '0;
         g_limit_q   <= '0;
         g_flag_q    <= 1'b0;
         bad_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         g_limit_q   <= g_limit_d;
         g_flag_q    <= g_flag_d;
         bad_start_q <= bad_start_d;
      end
   end

   // Next-state logic; base(L) = N - 2^(L+1) and g_limit = N - 2^L use one extra bit for N.
   always_comb begin
      layer_p1_c   = (LW + 1)'(entry_layer) + (LW + 1)'(1);
      base_wide_c  = N_FULL - ((CW + 1)'(1) << layer_p1_c);
      limit_wide_c = N_FULL - ((CW + 1)'(1) << entry_layer);
      legal_c      = (entry_layer <= MAX_LAYER);

      state_d     = state_q;
      counter_d   = counter_q;
      g_limit_d   = g_limit_q;
      g_flag_d    = g_flag_q;
      bad_start_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (legal_c) begin
                  counter_d = CW'(base_wide_c);
                  g_limit_d = CW'(limit_wide_c);
                  g_flag_d  = entry_is_g;
                  state_d   = ST_RUN;
               end else begin
                  bad_start_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (step_ready) begin
               if (counter_q == LAST) begin
                  state_d = ST_DONE;
               end else begin
                  counter_d = counter_q + CW'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Step qualifiers; a layer base is "ones then zeros", i.e. its complement is 0..01..1.
   always_comb begin
      inv_c         = ~counter_q;
      inv_p1_c      = inv_c + CW'(1);
      step_valid    = (state_q == ST_RUN);
      busy          = (state_q != ST_IDLE);
      descent_done  = (state_q == ST_DONE);
      bad_start     = bad_start_q;
      counter_value = counter_q;
      op_is_g       = step_valid & g_flag_q & (counter_q < g_limit_q);
      layer_first   = step_valid & ((inv_c & inv_p1_c) == '0) & (counter_q != '1);
   end

endmodule

// File: tb/tb_descent_step_sequencer.sv
// Bench for descent_step_sequencer: scenario tasks checked against a layer-map reference model.
module tb_descent_step_sequencer;

   localparam int unsigned CW = 10;
   localparam int unsigned LW = 4;
   localparam int N    = 1 << CW;
   localparam int LAST = N - 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] entry_layer;
   logic          entry_is_g;
   logic          abort;
   logic          step_ready;
   logic          step_valid;
   logic [CW-1:0] counter_value;
   logic          op_is_g;
   logic          layer_first;
   logic          busy;
   logic          descent_done;
   logic          bad_start;

   int n_cmp = 0;
   int n_err = 0;
   int held_counter = 0;

   descent_step_sequencer #(.COUNTER_WIDTH(CW), .LAYER_OUT_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .entry_layer(entry_layer),
      .entry_is_g(entry_is_g), .abort(abort), .step_ready(step_ready),
      .step_valid(step_valid), .counter_value(counter_value), .op_is_g(op_is_g),
      .layer_first(layer_first), .busy(busy), .descent_done(descent_done),
      .bad_start(bad_start)
   );

   always #5 clk = ~clk;

   // Reference: an index opens a layer when it equals N - 2^(k+1) for some layer k.
   function automatic bit is_layer_base(input int idx);
      for (int k = 0; k < int'(CW); k++)
         if (idx == N - (1 << (k + 1))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit exp_g(input int idx, input int layer, input bit g);
      return g && (idx < N - (1 << layer));
   endfunction

   // Flags order: step_valid, busy, descent_done, bad_start, op_is_g, layer_first.
   function automatic logic [5:0] flags();
      return {step_valid, busy, descent_done, bad_start, op_is_g, layer_first};
   endfunction

   // One descent; ready_mode 0 = always, 1 = 1,0,0 pattern, 2 = random.
   task automatic test_descent(input int layer, input bit g, input int ready_mode,
                               input int abort_at, input int restart_at,
                               input int restart_layer, input string name);
      int q[$];
      int cyc;
      int budget;
      bit rdy;
      bit aborting;
      logic [5:0] exp_f;
      for (int i = N - (1 << (layer + 1)); i <= LAST; i++) q.push_back(i);
      budget = 4 * q.size() + 10;
      entry_layer = LW'(layer);
      entry_is_g  = g;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (q.size() > 0 && cyc <= budget) begin
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 3) == 1);
            default: rdy = ($urandom_range(3) != 0);
         endcase
         step_ready = rdy;
         aborting   = (q[0] == abort_at);
         abort      = aborting;
         if (cyc == restart_at) begin
            start       = 1'b1;
            entry_layer = LW'(restart_layer);
         end
         @(negedge clk);
         exp_f = {1'b1, 1'b1, 1'b0, 1'b0, exp_g(q[0], layer, g), is_layer_base(q[0])};
         n_cmp++;
         if (flags() !== exp_f) begin
            n_err++;
            $display("FAIL %s step flags at idx %0d: got %b want %b", name, q[0], flags(), exp_f);
         end
         n_cmp++;
         if (counter_value !== CW'(q[0])) begin
            n_err++;
            $display("FAIL %s counter: got %0d want %0d", name, counter_value, q[0]);
         end
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         if (aborting) begin
            step_ready = 1'b0;
            held_counter = abort_at;
            repeat (2) begin
               @(negedge clk);
               n_cmp++;
               if (flags() !== 6'b0 || counter_value !== CW'(abort_at)) begin
                  n_err++;
                  $display("FAIL %s after abort: flags %b counter %0d want 000000 %0d",
                           name, flags(), counter_value, abort_at);
               end
               @(posedge clk); #1;
            end
            return;
         end
         if (rdy) void'(q.pop_front());
         cyc++;
      end
      step_ready = 1'b0;
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL %s timeout: %0d steps left want 0", name, q.size());
      end
      @(negedge clk);
      n_cmp++;
      if (flags() !== 6'b011000 || counter_value !== CW'(LAST)) begin
         n_err++;
         $display("FAIL %s done cycle: flags %b counter %0d want 011000 %0d",
                  name, flags(), counter_value, LAST);
      end
      if (ready_mode == 0) begin
         n_cmp++;
         if (cyc != (1 << (layer + 1))) begin
            n_err++;
            $display("FAIL %s done latency: got %0d want %0d", name, cyc, 1 << (layer + 1));
         end
      end
      held_counter = LAST;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (flags() !== 6'b0 || counter_value !== CW'(LAST)) begin
         n_err++;
         $display("FAIL %s idle after done: flags %b counter %0d", name, flags(), counter_value);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; entry_layer = '0; entry_is_g = 1'b0;
      abort = 1'b0; step_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (flags() !== 6'b0 || counter_value !== '0) begin
         n_err++;
         $display("FAIL reset: flags %b counter %0d want 000000 0", flags(), counter_value);
      end
      rst = 1'b0;
      held_counter = 0;
   endtask

   task automatic test_full_descent();
      test_descent(9, 1'b0, 0, -1, -1, 0, "full");
   endtask

   task automatic test_short_g();
      test_descent(2, 1'b1, 0, -1, -1, 0, "short_g");
   endtask

   task automatic test_leaf();
      test_descent(0, 1'b1, 0, -1, -1, 0, "leaf");
   endtask

   task automatic test_backpressure();
      test_descent(3, 1'b1, 1, -1, -1, 0, "backpressure");
   endtask

   task automatic test_illegal();
      int bad_layers[3] = '{10, 12, 15};
      foreach (bad_layers[i]) begin
         entry_layer = LW'(bad_layers[i]);
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (flags() !== 6'b000100 || counter_value !== CW'(held_counter)) begin
            n_err++;
            $display("FAIL illegal layer %0d: flags %b counter %0d want 000100 %0d",
                     bad_layers[i], flags(), counter_value, held_counter);
         end
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++;
         if (flags() !== 6'b0) begin
            n_err++;
            $display("FAIL illegal pulse width: flags %b want 000000", flags());
         end
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (flags() !== 6'b0 || counter_value !== CW'(held_counter)) begin
         n_err++;
         $display("FAIL idle abort: flags %b counter %0d want 000000 %0d",
                  flags(), counter_value, held_counter);
      end
   endtask

   task automatic test_start_during_run();
      test_descent(4, 1'b1, 0, -1, 5, 0, "restart_legal");
      test_descent(3, 1'b0, 1, -1, 4, 12, "restart_illegal");
   endtask

   task automatic test_back_to_back();
      test_descent(1, 1'b1, 0, -1, -1, 0, "b2b_a");
      test_descent(1, 1'b0, 0, -1, -1, 0, "b2b_b");
   endtask

   task automatic test_abort();
      test_descent(9, 1'b1, 2, 600, -1, 0, "abort600");
   endtask

   task automatic test_rst_mid_run();
      entry_layer = LW'(9); entry_is_g = 1'b1; step_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (flags() !== 6'b0 || counter_value !== '0) begin
         n_err++;
         $display("FAIL rst mid-run: flags %b counter %0d want 000000 0", flags(), counter_value);
      end
      held_counter = 0;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || descent_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst mid-run follow-up: busy %b done %b want 0 0", busy, descent_done);
         end
      end
      step_ready = 1'b0;
   endtask

   task automatic test_random();
      int layer;
      int abort_at;
      for (int it = 0; it < 12; it++) begin
         layer = $urandom_range(7);
         abort_at = -1;
         if ($urandom_range(3) == 0)
            abort_at = N - (1 << (layer + 1)) + $urandom_range((1 << (layer + 1)) - 2);
         test_descent(layer, 1'($urandom_range(1)), 2, abort_at, -1, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_full_descent();
      test_short_g();
      test_leaf();
      test_backpressure();
      test_illegal();
      test_start_during_run();
      test_back_to_back();
      test_abort();
      test_rst_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
